// File: rtl/con_csr_bank.sv
// Conduit-attached CSR bank: NUM_REGS RW control words, a RO status word and optional IRQ status/mask.
// Optional IRQ logic is compiled only when CON_CSR_BANK_IRQ_EN is defined.
module con_csr_bank #(
  parameter int unsigned D_WIDTH    = 32,
  parameter int unsigned A_WIDTH    = 12,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic                          con_wr,
  input  logic [A_WIDTH-1:0]            con_waddr,
  input  logic [D_WIDTH-1:0]            con_wdata,
  input  logic [D_WIDTH/8-1:0]          con_wbyte_enable,
  input  logic                          con_rd,
  input  logic [A_WIDTH-1:0]            con_raddr,
  input  logic [D_WIDTH/8-1:0]          con_rbyte_enable,
  input  logic                          con_rd_ack,
  output logic                          con_wr_ack,
  output logic [D_WIDTH-1:0]            con_rdata,
  output logic                          con_read_valid,
  output logic                          con_slv_error,
  output logic [NUM_REGS*D_WIDTH-1:0]   ctrl_q,
  input  logic [31:0]                   hw_status,
  input  logic [7:0]                    irq_src,
  output logic                          irq
);

  localparam int unsigned IW = A_WIDTH - 2;
  localparam int unsigned NB = D_WIDTH / 8;
  localparam int unsigned CW = 2;

  localparam logic [IW-1:0] IDX_NREGS    = IW'(NUM_REGS);
  localparam logic [IW-1:0] IDX_STATUS   = IW'(NUM_REGS);
  localparam logic [IW-1:0] IDX_IRQ_STAT = IW'(NUM_REGS + 1);
  localparam logic [IW-1:0] IDX_IRQ_MASK = IW'(NUM_REGS + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } rd_state_e;

  rd_state_e          state_q;
  logic [A_WIDTH-1:0] raddr_q;
  logic [CW-1:0]      cnt_q;
  logic               rd_err_q;

  logic [IW-1:0]      w_idx;
  logic               w_err_c;
  logic               w_ok_c;
  logic               w_err_pulse_c;
  logic [A_WIDTH-1:0] rd_addr_c;
  logic [IW-1:0]      rd_idx;
  logic [D_WIDTH-1:0] rd_data_c;
  logic               rd_err_c;

  logic unused_rbe;
  assign unused_rbe = ^con_rbyte_enable;

`ifdef CON_CSR_BANK_IRQ_EN
  logic [7:0] irq_stat_q;
  logic [7:0] irq_mask_q;
  logic [7:0] w1c_c;
`else
  logic unused_irq_src;
  assign unused_irq_src = ^irq_src;
`endif

  // Write address decode; STATUS is read-only so writing it is an error.
  always_comb begin
    w_idx   = con_waddr[A_WIDTH-1:2];
    w_err_c = 1'b1;
    if (con_waddr[1:0] == 2'b00) begin
      if (w_idx < IDX_NREGS) w_err_c = 1'b0;
`ifdef CON_CSR_BANK_IRQ_EN
      if (w_idx == IDX_IRQ_STAT || w_idx == IDX_IRQ_MASK) w_err_c = 1'b0;
`endif
    end
    w_ok_c        = con_wr & ~w_err_c;
    w_err_pulse_c = con_wr & w_err_c;
  end

  // With single-cycle latency the address is decoded straight off the bus.
  assign rd_addr_c = (RD_LATENCY == 1) ? con_raddr : raddr_q;

  always_comb begin
    rd_idx    = rd_addr_c[A_WIDTH-1:2];
    rd_data_c = '0;
    rd_err_c  = 1'b1;
    if (rd_addr_c[1:0] == 2'b00) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_idx == IW'(i)) begin
          rd_data_c = ctrl_q[i*D_WIDTH +: D_WIDTH];
          rd_err_c  = 1'b0;
        end
      end
      if (rd_idx == IDX_STATUS) begin
        rd_data_c = D_WIDTH'(hw_status);
        rd_err_c  = 1'b0;
      end
`ifdef CON_CSR_BANK_IRQ_EN
      if (rd_idx == IDX_IRQ_STAT) begin
        rd_data_c = D_WIDTH'(irq_stat_q);
        rd_err_c  = 1'b0;
      end
      if (rd_idx == IDX_IRQ_MASK) begin
        rd_data_c = D_WIDTH'(irq_mask_q);
        rd_err_c  = 1'b0;
      end
`endif
    end
  end

  // Byte-enabled control register writes.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl_q <= '0;
    end else if (w_ok_c) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_idx == IW'(i)) begin
          for (int b = 0; b < NB; b++) begin
            if (con_wbyte_enable[b]) ctrl_q[i*D_WIDTH + b*8 +: 8] <= con_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

`ifdef CON_CSR_BANK_IRQ_EN
  assign w1c_c = (w_ok_c && w_idx == IDX_IRQ_STAT && con_wbyte_enable[0]) ? con_wdata[7:0] : 8'h00;

  // Source set wins over a coincident W1C of the same bit.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq_stat_q <= '0;
      irq_mask_q <= '0;
      irq        <= 1'b0;
    end else begin
      irq_stat_q <= (irq_stat_q & ~w1c_c) | irq_src;
      if (w_ok_c && w_idx == IDX_IRQ_MASK && con_wbyte_enable[0]) irq_mask_q <= con_wdata[7:0];
      irq <= |(irq_stat_q & irq_mask_q);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Write ack and read FSM; slave error merges write-error pulse with read-error hold.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q        <= S_IDLE;
      raddr_q        <= '0;
      cnt_q          <= '0;
      rd_err_q       <= 1'b0;
      con_rdata      <= '0;
      con_read_valid <= 1'b0;
      con_slv_error  <= 1'b0;
      con_wr_ack     <= 1'b0;
    end else begin
      con_wr_ack    <= con_wr;
      con_slv_error <= w_err_pulse_c;
      case (state_q)
        S_IDLE: begin
          if (con_rd) begin
            raddr_q <= con_raddr;
            if (RD_LATENCY == 1) begin
              state_q        <= S_VALID;
              con_read_valid <= 1'b1;
              con_rdata      <= rd_data_c;
              rd_err_q       <= rd_err_c;
              con_slv_error  <= w_err_pulse_c | rd_err_c;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CW'(RD_LATENCY - 2);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q        <= S_VALID;
            con_read_valid <= 1'b1;
            con_rdata      <= rd_data_c;
            rd_err_q       <= rd_err_c;
            con_slv_error  <= w_err_pulse_c | rd_err_c;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_VALID: begin
          if (con_rd_ack) begin
            state_q        <= S_IDLE;
            con_read_valid <= 1'b0;
            con_rdata      <= '0;
            rd_err_q       <= 1'b0;
          end else begin
            con_slv_error <= w_err_pulse_c | rd_err_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_con_csr_bank.sv
// Scoreboard bench for con_csr_bank (RD_LATENCY=3); IRQ checks follow CON_CSR_BANK_IRQ_EN.
module tb_con_csr_bank;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned NR = 8;
  localparam int unsigned RL = 3;

  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic              con_wr = 1'b0;
  logic [AW-1:0]     con_waddr = '0;
  logic [DW-1:0]     con_wdata = '0;
  logic [DW/8-1:0]   con_wbyte_enable = '0;
  logic              con_rd = 1'b0;
  logic [AW-1:0]     con_raddr = '0;
  logic [DW/8-1:0]   con_rbyte_enable = '0;
  logic              con_rd_ack = 1'b0;
  logic              con_wr_ack;
  logic [DW-1:0]     con_rdata;
  logic              con_read_valid;
  logic              con_slv_error;
  logic [NR*DW-1:0]  ctrl_q;
  logic [31:0]       hw_status = '0;
  logic [7:0]        irq_src = '0;
  logic              irq;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     rq[$];
  logic        wq[$];
  logic [31:0] mdl [NR];

  con_csr_bank #(.D_WIDTH(DW), .A_WIDTH(AW), .NUM_REGS(NR), .RD_LATENCY(RL)) dut (
    .pclk(pclk), .presetn(presetn),
    .con_wr(con_wr), .con_waddr(con_waddr), .con_wdata(con_wdata), .con_wbyte_enable(con_wbyte_enable),
    .con_rd(con_rd), .con_raddr(con_raddr), .con_rbyte_enable(con_rbyte_enable), .con_rd_ack(con_rd_ack),
    .con_wr_ack(con_wr_ack), .con_rdata(con_rdata), .con_read_valid(con_read_valid),
    .con_slv_error(con_slv_error), .ctrl_q(ctrl_q), .hw_status(hw_status), .irq_src(irq_src), .irq(irq)
  );

  always #5 pclk = ~pclk;

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be, input logic exp_err);
    logic e;
    logic [AW-3:0] idx;
    wq.push_back(exp_err);
    con_wr = 1'b1; con_waddr = a; con_wdata = d; con_wbyte_enable = be;
    tick;
    con_wr = 1'b0;
    e = wq.pop_front();
    checks++;
    if (con_wr_ack !== 1'b1) begin
      failures++; $display("FAIL wr_ack addr=%h got=%b exp=1", a, con_wr_ack);
    end
    checks++;
    if (con_slv_error !== e) begin
      failures++; $display("FAIL wr_err addr=%h got=%b exp=%b", a, con_slv_error, e);
    end
    idx = a[AW-1:2];
    if (!exp_err && idx < (AW-2)'(NR))
      for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
    tick;
    checks++;
    if (con_wr_ack !== 1'b0) begin
      failures++; $display("FAIL wr_ack_pulse addr=%h got=%b exp=0", a, con_wr_ack);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] exp_d, input logic exp_e, input int hold);
    rd_exp_t x;
    int n;
    x.err = exp_e; x.data = exp_d;
    rq.push_back(x);
    con_rd = 1'b1; con_raddr = a; con_rbyte_enable = 4'hF;
    tick;
    con_rd = 1'b0;
    n = 1;
    while (!con_read_valid && n < 12) begin tick; n++; end
    checks++;
    if (n != RL) begin
      failures++; $display("FAIL rd_latency addr=%h got=%0d exp=%0d", a, n, RL);
    end
    x = rq.pop_front();
    checks++;
    if (con_rdata !== x.data) begin
      failures++; $display("FAIL rd_data addr=%h got=%h exp=%h", a, con_rdata, x.data);
    end
    checks++;
    if (con_slv_error !== x.err) begin
      failures++; $display("FAIL rd_err addr=%h got=%b exp=%b", a, con_slv_error, x.err);
    end
    for (int h = 0; h < hold; h++) begin
      tick;
      checks++;
      if (con_read_valid !== 1'b1 || con_rdata !== x.data || con_slv_error !== x.err) begin
        failures++;
        $display("FAIL rd_hold addr=%h cyc=%0d got=%b/%h/%b exp=1/%h/%b", a, h, con_read_valid, con_rdata,
                 con_slv_error, x.data, x.err);
      end
    end
    con_rd_ack = 1'b1;
    tick;
    con_rd_ack = 1'b0;
    checks++;
    if (con_read_valid !== 1'b0 || con_rdata !== 32'h0) begin
      failures++; $display("FAIL rd_release addr=%h got=%b/%h exp=0/0", a, con_read_valid, con_rdata);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    presetn = 1'b0;
    tick; tick;
    checks++;
    if (ctrl_q !== '0 || con_rdata !== '0 || con_wr_ack !== 1'b0 || con_read_valid !== 1'b0 ||
        con_slv_error !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got ctrl=%h rdata=%h ack=%b vld=%b err=%b irq=%b exp all 0", ctrl_q, con_rdata,
               con_wr_ack, con_read_valid, con_slv_error, irq);
    end
    presetn = 1'b1;
    tick;
  endtask

  task automatic test_ctrl_rw;
    logic [31:0] d;
    logic [3:0]  be;
    do_write(12'h004, 32'hA5A5_1234, 4'b0011, 1'b0);
    checks++;
    if (ctrl_q[63:32] !== 32'h0000_1234) begin
      failures++; $display("FAIL be_write got=%h exp=00001234", ctrl_q[63:32]);
    end
    for (int i = 0; i < NR; i++) begin
      d  = $urandom;
      be = 4'($urandom_range(1, 15));
      do_write(12'((i * 4)), d, be, 1'b0);
    end
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (ctrl_q[i*DW +: DW] !== mdl[i]) begin
        failures++; $display("FAIL ctrl_q reg=%0d got=%h exp=%h", i, ctrl_q[i*DW +: DW], mdl[i]);
      end
      do_read(12'((i * 4)), mdl[i], 1'b0, i % 3);
    end
  endtask

  task automatic test_status_read;
    hw_status = 32'hDEAD_BEEF;
    do_read(12'h020, 32'hDEAD_BEEF, 1'b0, 5);
  endtask

  task automatic test_errors;
    do_read(12'h0FC, 32'h0, 1'b1, 1);
    do_read(12'h005, 32'h0, 1'b1, 0);
    do_write(12'h002, 32'hFFFF_FFFF, 4'hF, 1'b1);
    do_write(12'h020, 32'h1111_1111, 4'hF, 1'b1);
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (ctrl_q[i*DW +: DW] !== mdl[i]) begin
        failures++; $display("FAIL err_no_change reg=%0d got=%h exp=%h", i, ctrl_q[i*DW +: DW], mdl[i]);
      end
    end
  endtask

`ifdef CON_CSR_BANK_IRQ_EN
  task automatic test_irq;
    do_write(12'h028, 32'hFFFF_FF01, 4'hF, 1'b0);
    do_read(12'h028, 32'h0000_0001, 1'b0, 0);
    irq_src = 8'h01;
    tick;
    irq_src = 8'h00;
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_lag got=%b exp=0", irq);
    end
    tick;
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL irq_rise got=%b exp=1", irq);
    end
    do_read(12'h024, 32'h0000_0001, 1'b0, 0);
    irq_src = 8'h01;
    do_write(12'h024, 32'h0000_0001, 4'hF, 1'b0);
    irq_src = 8'h00;
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL irq_set_wins got=%b exp=1", irq);
    end
    do_read(12'h024, 32'h0000_0001, 1'b0, 0);
    do_write(12'h024, 32'h0000_0001, 4'hF, 1'b0);
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL irq_clear got=%b exp=0", irq);
    end
    do_read(12'h024, 32'h0, 1'b0, 0);
  endtask
`else
  task automatic test_no_irq;
    do_read(12'h028, 32'h0, 1'b1, 0);
    do_write(12'h024, 32'h0000_00FF, 4'hF, 1'b1);
    irq_src = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (irq !== 1'b0) begin
        failures++; $display("FAIL irq_tied cyc=%0d got=%b exp=0", i, irq);
      end
    end
    irq_src = 8'h00;
  endtask
`endif

  task automatic test_back_to_back;
    rd_exp_t x;
    logic    e;
    logic    seen;
    int      n;
    mdl[2] = 32'h1357_9BDF;
    wq.push_back(1'b0);
    x.err = 1'b0; x.data = mdl[2];
    rq.push_back(x);
    con_wr = 1'b1; con_waddr = 12'h008; con_wdata = 32'h1357_9BDF; con_wbyte_enable = 4'hF;
    con_rd = 1'b1; con_raddr = 12'h008;
    tick;
    con_wr = 1'b0; con_rd = 1'b0;
    e = wq.pop_front();
    checks++;
    if (con_wr_ack !== 1'b1 || con_slv_error !== e) begin
      failures++; $display("FAIL b2b_wr_ack got=%b/%b exp=1/%b", con_wr_ack, con_slv_error, e);
    end
    n = 1;
    while (!con_read_valid && n < 12) begin tick; n++; end
    x = rq.pop_front();
    checks++;
    if (n != RL || con_rdata !== x.data) begin
      failures++; $display("FAIL b2b_rd got lat=%0d data=%h exp lat=%0d data=%h", n, con_rdata, RL, x.data);
    end
    con_rd = 1'b1; con_raddr = 12'h0FC;
    tick;
    con_rd = 1'b0;
    con_rd_ack = 1'b1;
    tick;
    con_rd_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (con_read_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL rd_ignored_busy got=%b exp=0", seen);
    end
  endtask

  task automatic test_reset_mid_read;
    logic seen;
    con_rd = 1'b1; con_raddr = 12'h004;
    tick;
    con_rd = 1'b0;
    presetn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    tick;
    presetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (con_read_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL rd_abandoned got=%b exp=0", seen);
    end
    checks++;
    if (ctrl_q !== '0) begin
      failures++; $display("FAIL ctrl_after_reset got=%h exp=0", ctrl_q);
    end
    do_read(12'h004, 32'h0, 1'b0, 0);
  endtask

  initial begin
    test_reset;
    test_ctrl_rw;
    test_status_read;
    test_errors;
`ifdef CON_CSR_BANK_IRQ_EN
    test_irq;
`else
    test_no_irq;
`endif
    test_back_to_back;
    test_reset_mid_read;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/con_csr_bank.md
CON_CSR_BANK -- requirements
Module: con_csr_bank

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, conduit data width (32 only).
REQ-002 SHALL have parameter A_WIDTH, default 12, conduit byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of RW control registers (1..64).
REQ-004 SHALL have parameter RD_LATENCY, default 1, cycles from con_rd to con_read_valid (1..4).
REQ-005 SHALL have ports pclk, input, 1, clock; presetn, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have ports con_wr in 1 write strobe; con_waddr in A_WIDTH; con_wdata in D_WIDTH; con_wbyte_enable in D_WIDTH/8.
REQ-007 SHALL have ports con_rd in 1 read strobe; con_raddr in A_WIDTH; con_rbyte_enable in D_WIDTH/8 (ignored, full-word reads); con_rd_ack in 1 read-data consumed.
REQ-008 SHALL have outputs con_wr_ack 1; con_rdata D_WIDTH; con_read_valid 1; con_slv_error 1.
REQ-009 SHALL have ports ctrl_q out NUM_REGS*D_WIDTH (register i at bits [i*32+:32]); hw_status in 32; irq_src in 8; irq out 1.

Function
REQ-010 SHALL decode word index = addr[A_WIDTH-1:2]: 0..NUM_REGS-1 CTRL (RW); NUM_REGS STATUS (RO, hw_status); NUM_REGS+1 IRQ_STAT (W1C, bits [7:0]); NUM_REGS+2 IRQ_MASK (RW, bits [7:0]); other indices unmapped.
REQ-011 SHALL treat addr[1:0]!=0, unmapped index, or write to STATUS as an error access.
REQ-012 SHALL, on con_wr, apply byte-enabled write at the next pclk edge and pulse con_wr_ack for exactly one cycle, one cycle after con_wr.
REQ-013 SHALL, on an error write, leave all registers unchanged and assert con_slv_error in the same cycle as con_wr_ack.
REQ-014 SHALL implement read FSM IDLE -> WAIT -> VALID -> IDLE; con_rd in IDLE latches con_raddr and enters WAIT (RD_LATENCY=1 skips WAIT, entering VALID directly).
REQ-015 SHALL remain in WAIT for RD_LATENCY-1 cycles, then register read data and enter VALID, so con_read_valid rises RD_LATENCY cycles after con_rd.
REQ-016 SHALL hold con_read_valid and con_rdata stable in VALID until con_rd_ack is sampled high, then return to IDLE next cycle.
REQ-017 SHALL drive con_rdata=0 and assert con_slv_error, for the whole VALID period, on an error read.
REQ-018 SHALL ignore con_rd outside IDLE (no queueing).
REQ-019 SHALL process con_wr and con_rd in the same cycle independently; read data reflects all writes acknowledged before entering VALID.
REQ-020 SHALL bound unused IRQ_STAT/IRQ_MASK bits [31:8] to read 0 and ignore writes.
REQ-021 SHALL set IRQ_STAT[i] when irq_src[i]=1; set SHALL win over simultaneous W1C of the same bit.
REQ-022 SHALL drive irq registered as |(IRQ_STAT & IRQ_MASK), one cycle after the state change.
REQ-023 SHALL drive con_rdata=0 whenever con_read_valid=0.

Reset
REQ-024 SHALL, while presetn=0, force FSM to IDLE and all CTRL, IRQ_STAT, IRQ_MASK, con_rdata, con_wr_ack, con_read_valid, con_slv_error, irq to 0.
REQ-025 SHALL abandon any in-flight read on reset; no con_read_valid SHALL appear after reset release without a new con_rd.

Configuration
REQ-026 SHALL compile IRQ logic only when macro CON_CSR_BANK_IRQ_EN is defined.
REQ-027 SHALL, without CON_CSR_BANK_IRQ_EN, treat indices NUM_REGS+1 and NUM_REGS+2 as unmapped (error), ignore irq_src, and tie irq=0.

Verification
REQ-028 Write 0xA5A5_1234 to 0x004 with be=4'b0011 over reset value -> ctrl_q[63:32]=0x0000_1234, con_wr_ack one cycle later, con_slv_error=0.
REQ-029 RD_LATENCY=3, con_rd at 0x020 (STATUS, hw_status=0xDEAD_BEEF), con_rd_ack held low 5 cycles -> con_read_valid rises 3 cycles after con_rd, data stable 0xDEAD_BEEF until ack, FSM IDLE next cycle.
REQ-030 Read 0x0FC and write 0x002 -> read: valid with con_slv_error=1, con_rdata=0; write: con_wr_ack with con_slv_error=1, no register change.
REQ-031 IRQ_MASK=0x01, irq_src[0] pulse -> IRQ_STAT=0x01, irq=1 next cycle; W1C 0x01 coincident with irq_src[0] -> bit stays 1; W1C alone -> irq=0.
REQ-032 presetn low during WAIT of a read -> con_read_valid never asserts; next con_rd after release completes normally.
REQ-033 Without CON_CSR_BANK_IRQ_EN, read index NUM_REGS+2 -> con_slv_error=1; irq_src=0xFF -> irq stays 0.
